distance_pulse_gen: RTL and testbench

//  Transmit side of the distance-pulse interface: emits a train of sensor-style pulses encoding a

---
 rtl/distance_pulse_gen_pkg.sv | 23 ++
 rtl/distance_pulse_gen_if.sv | 39 +++
 rtl/distance_pulse_gen_pulse_phase_timer.sv | 40 ++++
 rtl/distance_pulse_gen.sv | 183 ++++++++++++++++++
 tb/tb_distance_pulse_gen.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/distance_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// distance_pulse_gen_pkg
//   Shared constants for the distance-pulse transmitter. The pulse scaling and
//   units width are the same values the distance counter uses, so a loopback
//   of this generator into the counter reads back the requested distance.
//   Contents:
//     PULSES_PER_UNIT_DEF  pulses per half-unit (1024 pulses = 0.5 mile)
//     UNIT_W_DEF           width of the units request / units_sent report
//     PERIOD_W_DEF         width of the period request (clk cycles per pulse)
//     ST_*                 FSM state encodings shared with the counter side
// -----------------------------------------------------------------------------
package distance_pulse_gen_pkg;

  localparam int PULSES_PER_UNIT_DEF = 1024;
  localparam int UNIT_W_DEF          = 7;
  localparam int PERIOD_W_DEF        = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HIGH   = 2'd1;
  localparam logic [1:0] ST_LOW    = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage : distance_pulse_gen_pkg

// File: rtl/distance_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// distance_pulse_gen_if
//   Request/report bundle of the distance-pulse transmitter.
//   Signals:
//     start       requester -> gen  start a train (taken only when idle)
//     units       requester -> gen  half-units to emit
//     period      requester -> gen  clk cycles per pulse
//     abort       requester -> gen  terminate the running train
//     pulse       gen -> requester  sensor-style pulse output
//     busy        gen -> requester  train in progress
//     done        gen -> requester  one-cycle completion/abort strobe
//     units_sent  gen -> requester  half-units fully emitted
//   Modports: master = requester side, slave = generator side.
// -----------------------------------------------------------------------------
interface distance_pulse_gen_if #(
  parameter int UNIT_W   = distance_pulse_gen_pkg::UNIT_W_DEF,
  parameter int PERIOD_W = distance_pulse_gen_pkg::PERIOD_W_DEF
);

  logic                start;
  logic [UNIT_W-1:0]   units;
  logic [PERIOD_W-1:0] period;
  logic                abort;
  logic                pulse;
  logic                busy;
  logic                done;
  logic [UNIT_W-1:0]   units_sent;

  modport master (
    output start, units, period, abort,
    input  pulse, busy, done, units_sent
  );

  modport slave (
    input  start, units, period, abort,
    output pulse, busy, done, units_sent
  );

endinterface : distance_pulse_gen_if

// File: rtl/distance_pulse_gen_pulse_phase_timer.sv
// -----------------------------------------------------------------------------
// distance_pulse_gen_pulse_phase_timer
//   Down-counter timing one phase (high or low) of a pulse. Loading a value V
//   makes expire assert on the V-th cycle after the load edge, i.e. the phase
//   lasts exactly V cycles. The same timer is reloaded for the high and low
//   phases in turn.
//   Ports:
//     clk         system clock
//     reset_n     asynchronous active-low reset
//     load        load load_value this edge (takes priority over counting)
//     load_value  phase length in cycles (>= 1)
//     expire      high during the last cycle of the loaded phase
// -----------------------------------------------------------------------------
module distance_pulse_gen_pulse_phase_timer #(
  parameter int W = distance_pulse_gen_pkg::PERIOD_W_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         expire
);

  logic [W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its inputs regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign expire = (count == W'(1));

endmodule : distance_pulse_gen_pulse_phase_timer

// File: rtl/distance_pulse_gen.sv
// -----------------------------------------------------------------------------
// distance_pulse_gen
//   Transmit side of the distance-pulse interface. On start it emits
//   units * PULSES_PER_UNIT pulses of period max(period,2) cycles (high for
//   P>>1 cycles, low for the remainder), reports completed half-units on
//   units_sent and strobes done for one cycle on completion or abort.
//   Ports:
//     clk      system clock, all logic on posedge
//     reset_n  asynchronous active-low reset
//     bus      distance_pulse_gen_if.slave: start/units/period/abort in,
//              pulse/busy/done/units_sent out
// -----------------------------------------------------------------------------
module distance_pulse_gen
  import distance_pulse_gen_pkg::*;
#(
  parameter int PULSES_PER_UNIT = PULSES_PER_UNIT_DEF,
  parameter int UNIT_W          = UNIT_W_DEF,
  parameter int PERIOD_W        = PERIOD_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  distance_pulse_gen_if.slave  bus
);

  localparam int CNT_W = $clog2(PULSES_PER_UNIT) + 1;

  logic [1:0]          state;
  logic [UNIT_W-1:0]   units_q;
  logic [UNIT_W-1:0]   units_sent_q;
  logic [PERIOD_W-1:0] high_q;
  logic [PERIOD_W-1:0] low_q;
  logic [CNT_W-1:0]    pulse_cnt;
  logic                pulse_q;
  logic                busy_q;
  logic                done_q;

  // Clamped period and its split, computed from the live request so they can
  // be latched on the accepting edge.
  logic [PERIOD_W-1:0] period_clamped;
  logic [PERIOD_W-1:0] high_in;
  logic [PERIOD_W-1:0] low_in;

  assign period_clamped = (bus.period < PERIOD_W'(2)) ? PERIOD_W'(2) : bus.period;
  assign high_in        = period_clamped >> 1;
  assign low_in         = period_clamped - high_in;

  logic start_taken;
  logic last_pulse_of_unit;
  logic last_unit;

  assign start_taken        = (state == ST_IDLE) && bus.start;
  assign last_pulse_of_unit = (pulse_cnt == CNT_W'(PULSES_PER_UNIT - 1));
  // units_sent_q < units_q whenever this is consulted, so +1 cannot wrap.
  assign last_unit          = ((units_sent_q + UNIT_W'(1)) == units_q);

  // Phase timer: reloaded with H when a high phase begins and with L when a
  // low phase begins. Reloading on the final low phase before FINISH is
  // harmless; the timer is ignored outside HIGH/LOW.
  logic                tmr_load;
  logic [PERIOD_W-1:0] tmr_value;
  logic                tmr_expire;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = high_q;
    case (state)
      ST_IDLE: begin
        tmr_load  = bus.start;
        tmr_value = high_in;
      end
      ST_HIGH: begin
        tmr_load  = tmr_expire;
        tmr_value = low_q;
      end
      ST_LOW: begin
        tmr_load  = tmr_expire;
        tmr_value = high_q;
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = high_q;
      end
    endcase
  end

  distance_pulse_gen_pulse_phase_timer #(
    .W (PERIOD_W)
  ) u_phase_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .expire     (tmr_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      units_q      <= '0;
      units_sent_q <= '0;
      high_q       <= '0;
      low_q        <= '0;
      pulse_cnt    <= '0;
      pulse_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          // abort is ignored here, so start wins when both are present.
          if (start_taken) begin
            units_q      <= bus.units;
            high_q       <= high_in;
            low_q        <= low_in;
            units_sent_q <= '0;
            pulse_cnt    <= '0;
            busy_q       <= 1'b1;
            if (bus.units == '0) begin
              state <= ST_FINISH;
            end else begin
              state   <= ST_HIGH;
              pulse_q <= 1'b1;
            end
          end
        end

        ST_HIGH: begin
          if (bus.abort) begin
            pulse_q   <= 1'b0;
            pulse_cnt <= '0;
            state     <= ST_FINISH;
          end else if (tmr_expire) begin
            pulse_q <= 1'b0;
            state   <= ST_LOW;
          end
        end

        ST_LOW: begin
          // Abort beats a simultaneous unit completion: the unit is not
          // credited to units_sent.
          if (bus.abort) begin
            pulse_cnt <= '0;
            state     <= ST_FINISH;
          end else if (tmr_expire) begin
            if (last_pulse_of_unit) begin
              pulse_cnt    <= '0;
              units_sent_q <= units_sent_q + UNIT_W'(1);
              if (last_unit) begin
                state <= ST_FINISH;
              end else begin
                state   <= ST_HIGH;
                pulse_q <= 1'b1;
              end
            end else begin
              pulse_cnt <= pulse_cnt + CNT_W'(1);
              state     <= ST_HIGH;
              pulse_q   <= 1'b1;
            end
          end
        end

        ST_FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.pulse      = pulse_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.units_sent = units_sent_q;

endmodule : distance_pulse_gen

// File: tb/tb_distance_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_distance_pulse_gen
//   Directed bench for distance_pulse_gen. Each started train pushes its
//   expected outcome (units_sent, pulse count, start-to-done latency, first
//   high/low widths) onto a scoreboard; the outcome is popped and compared
//   when done strobes. Pulse rising edges are counted independently.
// -----------------------------------------------------------------------------
module tb_distance_pulse_gen;

  localparam int PPU = 1024;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  distance_pulse_gen_if dif ();

  distance_pulse_gen u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  typedef struct {
    string tag;
    int    units_sent;
    int    pulses;
    int    latency;
    int    hi;
    int    lo;
    bit    chk_lat;
    bit    chk_shape;
  } exp_t;

  exp_t sb[$];

  int vectors    = 0;
  int miscompares = 0;
  int rise_cnt   = 0;
  int snap       = 0;

  always @(posedge dif.pulse) rise_cnt <= rise_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start on the next falling edge and record what the
  // train should produce.
  task automatic start_train(input string tag, input int u, input int p,
                             input int exp_us, input int exp_pulses, input bit chk_lat);
    exp_t e;
    int   pc;
    pc = (p < 2) ? 2 : p;
    e.tag        = tag;
    e.units_sent = exp_us;
    e.pulses     = exp_pulses;
    e.latency    = (u == 0) ? 2 : u * PPU * pc + 2;
    e.hi         = pc / 2;
    e.lo         = pc - pc / 2;
    e.chk_lat    = chk_lat;
    e.chk_shape  = chk_lat && (exp_pulses > 0);
    @(negedge clk);
    dif.start  = 1'b1;
    dif.units  = 7'(u);
    dif.period = 16'(p);
    snap       = rise_cnt;
    sb.push_back(e);
  endtask

  // Follow the running train until done (bounded). n counts falling edges
  // since the start was driven. At cycle inj (if > 0) a conflicting start
  // with different units/period is pulsed for one cycle.
  task automatic run_to_done(input int start_n, input int inj, output int pulses);
    int   n;
    bit   got;
    bit   gap;
    int   phase;
    int   hi;
    int   lo;
    exp_t e;
    n = start_n; got = 0; gap = 0; phase = 0; hi = 0; lo = 0;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (n == 1) dif.start = 1'b0;
      if (inj > 0 && n == inj) begin
        dif.start  = 1'b1;
        dif.units  = 7'd5;
        dif.period = 16'd7;
      end
      if (inj > 0 && n == inj + 1) dif.start = 1'b0;
      if (dif.done) begin
        got = 1;
        break;
      end
      if (!dif.busy) gap = 1;
      case (phase)
        0: if (dif.pulse) begin phase = 1; hi = 1; end
        1: if (dif.pulse) hi++; else begin phase = 2; lo = 1; end
        2: if (dif.pulse) phase = 3; else lo++;
        default: ;
      endcase
    end
    pulses = rise_cnt - snap;
    if (sb.size() == 0) begin
      check("scoreboard_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s.done_seen", e.tag), 32'(got), 32'd1);
      check($sformatf("%s.units_sent", e.tag), 32'(dif.units_sent), 32'(e.units_sent));
      check($sformatf("%s.pulses", e.tag), 32'(pulses), 32'(e.pulses));
      check($sformatf("%s.busy_at_done", e.tag), 32'(dif.busy), 32'd0);
      if (e.chk_lat) begin
        check($sformatf("%s.latency", e.tag), 32'(n), 32'(e.latency));
        check($sformatf("%s.busy_gap", e.tag), 32'(gap), 32'd0);
      end
      if (e.chk_shape) begin
        check($sformatf("%s.high_width", e.tag), 32'(hi), 32'(e.hi));
        check($sformatf("%s.low_width", e.tag), 32'(lo), 32'(e.lo));
      end
      @(negedge clk);
      check($sformatf("%s.done_single", e.tag), 32'(dif.done), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    int n;
    dif.start  = 1'b0;
    dif.units  = '0;
    dif.period = '0;
    dif.abort  = 1'b0;
    reset_n    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset.pulse", 32'(dif.pulse), 32'd0);
    check("reset.busy", 32'(dif.busy), 32'd0);
    check("reset.done", 32'(dif.done), 32'd0);
    check("reset.units_sent", 32'(dif.units_sent), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_reset.pulse", 32'(dif.pulse), 32'd0);

    // One half-unit at period 4: 2 high / 2 low
    start_train("u1_p4", 1, 4, 1, PPU, 1'b1);
    run_to_done(0, 0, pulses);

    // Zero units: no pulses, done two cycles after start
    start_train("u0", 0, 6, 0, 0, 1'b1);
    run_to_done(0, 0, pulses);

    // Period clamp and odd-period split
    start_train("p0", 1, 0, 1, PPU, 1'b1);
    run_to_done(0, 0, pulses);
    start_train("p1", 1, 1, 1, PPU, 1'b1);
    run_to_done(0, 0, pulses);
    start_train("p5", 1, 5, 1, PPU, 1'b1);
    run_to_done(0, 0, pulses);

    // Abort after 2500 pulses of a 3-unit train
    start_train("abort", 3, 2, 2, 2500, 1'b0);
    n = 0;
    while (n < 10000 && (rise_cnt - snap) != 2500) begin
      @(negedge clk);
      n++;
      if (n == 1) dif.start = 1'b0;
    end
    check("abort.reached_2500", 32'(rise_cnt - snap), 32'd2500);
    dif.abort = 1'b1;
    @(negedge clk);
    n++;
    dif.abort = 1'b0;
    check("abort.pulse_low_next", 32'(dif.pulse), 32'd0);
    check("abort.units_sent_mid", 32'(dif.units_sent), 32'd2);
    run_to_done(n, 0, pulses);

    // Start re-pulsed while busy (units=5, period=7) must be ignored
    start_train("restart_ignored", 3, 2, 3, 3 * PPU, 1'b1);
    run_to_done(0, 100, pulses);

    // Reset mid-train: asynchronous clear, no done strobe, then recovery
    start_train("reset_mid", 2, 2, 0, 0, 1'b0);
    n = 0;
    repeat (2100) begin
      @(negedge clk);
      n++;
      if (n == 1) dif.start = 1'b0;
    end
    check("reset_mid.units_sent_before", 32'(dif.units_sent), 32'd1);
    check("reset_mid.busy_before", 32'(dif.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid.pulse", 32'(dif.pulse), 32'd0);
    check("reset_mid.busy", 32'(dif.busy), 32'd0);
    check("reset_mid.done", 32'(dif.done), 32'd0);
    check("reset_mid.units_sent", 32'(dif.units_sent), 32'd0);
    void'(sb.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_mid.no_done", 32'(dif.done), 32'd0);
    end
    reset_n = 1'b1;
    start_train("after_reset_p3", 1, 3, 1, PPU, 1'b1);
    run_to_done(0, 0, pulses);

    // Loopback: 4 half-units at period 2 must read as 2.0 miles downstream
    start_train("loopback", 4, 2, 4, 4 * PPU, 1'b1);
    run_to_done(0, 0, pulses);
    check("loopback.miles_x10", 32'((pulses * 10) / (2 * PPU)), 32'd20);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_distance_pulse_gen
